// File: rtl/pc_unit.sv
// Program-counter unit for the multi-cycle MIPS datapath: fetch handshake, next-PC select,
// retired-instruction counting and a sticky halt on a misaligned jr target.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pc_op,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      jr_target,
  input  logic             exec_done,
  input  logic             im_ack,
  output logic             im_req,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fault_q, fault_d;
  logic             im_req_q, im_req_d;
  logic             halted_q, halted_d;

  logic [31:0] npc;
  logic [31:0] br_off;
  logic        jr_bad;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};
  assign jr_bad   = (pc_op == 2'b11) && (jr_target[1:0] != 2'b00);

  always_comb begin
    npc = pc_plus4;
    unique case (pc_op)
      2'b00: npc = pc_plus4;
      2'b01: npc = pc_plus4 + br_off;
      2'b10: npc = {pc_plus4[31:28], instr_index, 2'b00};
      2'b11: npc = jr_target;
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (im_ack) state_d = StExec;
      StExec: begin
        if (exec_done) begin
          if (jr_bad) begin
            // PC and count are frozen so the faulting instruction stays visible.
            state_d = StHalt;
            fault_d = 1'b1;
          end else begin
            pc_d      = npc;
            retired_d = retired_q + CNT_W'(1);
            state_d   = StFetch;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    // Outputs are registered from the next state so they line up with it.
    im_req_d = (state_d == StFetch);
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      fault_q   <= 1'b0;
      im_req_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      im_req_q  <= im_req_d;
      halted_q  <= halted_d;
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;
  assign fault   = fault_q;
  assign im_req  = im_req_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: two instances (default and wrap-around parameters) share stimulus;
// a monitor checks PC/count each time a new fetch request appears.
module tb_pc_unit;

  localparam logic [31:0] RST1 = 32'h0000_3000;
  localparam logic [31:0] RST2 = 32'hFFFF_FFFC;

  logic        clk, rst_n;
  logic [1:0]  pc_op;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic        exec_done, im_ack;

  logic        im_req, halted, fault;
  logic [31:0] pc, pc_plus4, retired;
  logic        im_req2, halted2, fault2;
  logic [31:0] pc2, pc_plus42;
  logic [1:0]  retired2;

  pc_unit #(.RESET_PC(RST1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .pc_op(pc_op), .imm16(imm16), .instr_index(instr_index),
    .jr_target(jr_target), .exec_done(exec_done), .im_ack(im_ack), .im_req(im_req), .pc(pc),
    .pc_plus4(pc_plus4), .halted(halted), .fault(fault), .retired(retired)
  );

  pc_unit #(.RESET_PC(RST2), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pc_op(pc_op), .imm16(imm16), .instr_index(instr_index),
    .jr_target(jr_target), .exec_done(exec_done), .im_ack(im_ack), .im_req(im_req2), .pc(pc2),
    .pc_plus4(pc_plus42), .halted(halted2), .fault(fault2), .retired(retired2)
  );

  typedef struct {
    logic [31:0] pc1;
    logic [31:0] ret1;
    logic [31:0] pc2;
    logic [1:0]  ret2;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_pc, m_pc2, m_ret;
  logic        req_prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC, written straight from the ISA rules.
  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [1:0] op,
                                            input logic [15:0] imm, input logic [25:0] idx,
                                            input logic [31:0] jr);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = int'($signed(imm)) * 4;
    case (op)
      2'd0:    return seq;
      2'd1:    return seq + 32'(off);
      2'd2:    return {seq[31:28], idx, 2'b00};
      default: return jr;
    endcase
  endfunction

  task automatic push_exp();
    exp_t e;
    e.pc1  = m_pc;
    e.ret1 = m_ret;
    e.pc2  = m_pc2;
    e.ret2 = m_ret[1:0];
    sb.push_back(e);
  endtask

  // Monitor: every fresh fetch request must present the expected PC and count.
  always @(negedge clk) begin
    if (rst_n && im_req && !req_prev) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pc", pc, e.pc1);
        chk("retired", retired, e.ret1);
        chk("pc_wrap", pc2, e.pc2);
        chk("retired_wrap", {30'd0, retired2}, {30'd0, e.ret2});
        chk("req_wrap", {31'd0, im_req2}, 32'd1);
      end
    end
    req_prev <= im_req;
  end

  task automatic wait_req();
    int n = 0;
    while (!im_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!im_req) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_instr(input logic [1:0] op, input logic [15:0] imm, input logic [25:0] idx,
                           input logic [31:0] jr, input int stall, input int edly);
    wait_req();
    for (int i = 0; i < stall; i++) begin
      chk("stall_pc", pc, m_pc);
      chk("stall_req", {31'd0, im_req}, 32'd1);
      exec_done = 1'($urandom % 2);
      @(negedge clk);
    end
    exec_done = 1'b0;
    im_ack    = 1'b1;
    @(negedge clk);
    im_ack = 1'b0;
    for (int i = 0; i < edly; i++) begin
      im_ack = 1'($urandom % 2);
      chk("exec_req", {31'd0, im_req}, 32'd0);
      chk("link", pc_plus4, m_pc + 32'd4);
      @(negedge clk);
    end
    im_ack = 1'b0;
    chk("link", pc_plus4, m_pc + 32'd4);
    pc_op       = op;
    imm16       = imm;
    instr_index = idx;
    jr_target   = jr;
    exec_done   = 1'b1;
    if (!(op == 2'b11 && jr[1:0] != 2'b00)) begin
      m_pc  = model_npc(m_pc, op, imm, idx, jr);
      m_pc2 = model_npc(m_pc2, op, imm, idx, jr);
      m_ret = m_ret + 32'd1;
      push_exp();
    end
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; exec_done = 1'b0; im_ack = 1'b0;
    pc_op = 2'b00; imm16 = '0; instr_index = '0; jr_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, RST1);
    chk("rst_link", pc_plus4, RST1 + 32'd4);
    chk("rst_retired", retired, 32'd0);
    chk("rst_flags", {29'd0, im_req, fault, halted}, 32'd0);
    m_pc = RST1; m_pc2 = RST2; m_ret = 0;
    push_exp();
    rst_n = 1'b1;
    chk("req_cycle1", {31'd0, im_req}, 32'd0);
    @(posedge clk); #1;
    chk("req_cycle2", {31'd0, im_req}, 32'd1);
    @(negedge clk);

    // Sequential, then directed branch / jump / jr cases.
    repeat (3) run_instr(2'b00, 16'h0, 26'h0, 32'h0, 0, 0);
    wait_req();
    chk("seq_pc", pc, 32'h0000_300C);
    chk("seq_ret", retired, 32'd3);
    chk("wrap_pc_seq", pc2, 32'h0000_0008);
    run_instr(2'b11, 16'h0, 26'h0, 32'h0000_3010, 0, 0);
    run_instr(2'b01, 16'hFFFC, 26'h0, 32'h0, 0, 0);
    wait_req();
    chk("br_back", pc, 32'h0000_3004);
    run_instr(2'b11, 16'h0, 26'h0, 32'h0000_3010, 0, 0);
    run_instr(2'b01, 16'h0003, 26'h0, 32'h0, 0, 0);
    wait_req();
    chk("br_fwd", pc, 32'h0000_3020);
    run_instr(2'b11, 16'h0, 26'h0, 32'h0000_3000, 0, 1);
    run_instr(2'b10, 16'h0, 26'h000_0C10, 32'h0, 0, 1);
    wait_req();
    chk("jal", pc, 32'h0000_3040);
    run_instr(2'b11, 16'h0, 26'h0, 32'h0000_3004, 0, 0);
    run_instr(2'b00, 16'h0, 26'h0, 32'h0, 5, 0);

    // Random legal instructions with random handshake stalls.
    for (int k = 0; k < 60; k++) begin
      run_instr(2'($urandom % 4), 16'($urandom), 26'($urandom), $urandom & 32'hFFFF_FFFC,
                int'($urandom % 3), int'($urandom % 3));
    end

    // Reset during EXEC aborts the instruction.
    wait_req();
    im_ack = 1'b1;
    @(negedge clk);
    im_ack    = 1'b0;
    exec_done = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("abort_pc", pc, RST1);
    chk("abort_ret", retired, 32'd0);
    chk("abort_req", {31'd0, im_req}, 32'd0);
    sb.delete();
    m_pc = RST1; m_pc2 = RST2; m_ret = 0;
    push_exp();
    @(negedge clk);
    exec_done = 1'b0;
    rst_n     = 1'b1;
    for (int k = 0; k < 4; k++) run_instr(2'b00, 16'h0, 26'h0, 32'h0, 0, 0);
    wait_req();
    chk("cnt2_wrap", {30'd0, retired2}, 32'd0);

    // Misaligned jr halts both instances.
    run_instr(2'b11, 16'h0, 26'h0, 32'h0000_3006, 0, 0);
    for (int k = 0; k < 6; k++) begin
      chk("halt_pc", pc, m_pc);
      chk("halt_ret", retired, m_ret);
      chk("halt_flags", {29'd0, im_req, fault, halted}, 32'd3);
      chk("halt_flags_wrap", {29'd0, im_req2, fault2, halted2}, 32'd3);
      exec_done = 1'($urandom % 2);
      im_ack    = 1'($urandom % 2);
      pc_op     = 2'b00;
      @(negedge clk);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter unit of the multi-cycle MIPS datapath. It holds the PC, fetches each instruction through a request/acknowledge handshake with instruction memory, and computes the next PC. It acts on the 2-bit `pc_op` produced by the PC-select logic: 00 sequential, 01 taken branch, 10 j/jal, 11 jr. It also provides the jal link value, a retired-instruction counter, and a sticky fault/halt for a misaligned jr target.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, **asynchronous and active-low**.
- `pc_op` in 2: next-PC select from PC-select logic; valid only when `exec_done`=1.
- `imm16` in 16: branch offset field; valid with `exec_done`.
- `instr_index` in 26: j/jal target field; valid with `exec_done`.
- `jr_target` in 32: register value for jr; valid with `exec_done`.
- `exec_done` in 1: datapath has finished the current instruction this cycle.
- `im_ack` in 1: instruction memory has accepted the request for `pc`.
- `im_req` out 1: fetch request for address `pc`.
- `pc` out 32: current PC, registered.
- `pc_plus4` out 32: `pc`+4, combinational; used as the jal link value.
- `halted` out 1: unit is stopped in HALT.
- `fault` out 1: sticky flag for a misaligned jr target.
- `retired` out CNT_W: count of completed instructions.

## Operation
- FSM states are IDLE, FETCH, EXEC and HALT. The unit enters IDLE on reset.
- **IDLE**: `im_req`=0. Moves to FETCH unconditionally on the next edge. The purpose is one dead cycle after reset release.
- **FETCH**: `im_req`=1. If `im_ack`=1, moves to EXEC. Otherwise it stays in FETCH with `im_req` held high and `pc` stable.
- **EXEC**: `im_req`=0. The unit waits for `exec_done`=1 and then computes `npc`:
  - 00: `pc`+4.
  - 01: `pc`+4+(sign_extend(`imm16`)<<2).
  - 10: {(`pc`+4)[31:28], `instr_index`, 2'b00}.
  - 11: `jr_target`.
- In EXEC, when `exec_done`=1 and the jr target is legal: `pc` is loaded with `npc`, `retired` increments by 1, and the FSM returns to FETCH.
- Misaligned jr: `pc_op`=11 with `jr_target[1:0]`≠0. Then `pc` is unchanged, `retired` is unchanged, `fault` is set to 1, and the FSM goes to HALT.
- **HALT**: `im_req`=0 and `halted`=1. All inputs are ignored. Only `rst_n` leaves HALT.
- All PC arithmetic is modulo 2^32. Wrap-around is silent and is not a fault. Misaligned branch or jump targets cannot occur because the low bits are forced to 00.
- `retired` wraps from 2^CNT_W−1 to 0 with no flag.
- Inputs outside their valid state are ignored: `im_ack` outside FETCH, and `exec_done` outside EXEC.

## Timing
- Reset values (async, immediate on `rst_n`=0):
  - state=IDLE, `pc`=RESET_PC, `im_req`=0, `retired`=0, `fault`=0, `halted`=0.
  - `pc_plus4`=RESET_PC+4.
- Asserting `rst_n` mid-fetch or mid-exec aborts the operation at once. No PC update and no count increment occur.
- First `im_req` is high in the second cycle after `rst_n` is released.
- Minimum throughput is 2 cycles per instruction: `im_ack` in the first FETCH cycle, then `exec_done` in the first EXEC cycle.
- `pc` and `retired` change on the edge that samples `exec_done`=1 in EXEC. `im_req` rises in the cycle immediately after that edge.
- `fault` and `halted` go high on the edge that samples a misaligned jr. Both are registered.
- The `pc_plus4` used for jal link is valid throughout EXEC. It refers to the instruction being executed.

## Test plan
- Reset then sequential execution: release `rst_n`, ack every fetch in 1 cycle, `pc_op`=00 three times. Expect `pc` 0x3000→0x3004→0x3008→0x300C, `retired`=3, `im_req` first high in cycle 2.
- Taken branch backward: `pc`=0x3010, `pc_op`=01, `imm16`=16'hFFFC. Expect `pc`=0x3004. With `imm16`=16'h0003, expect `pc`=0x3020.
- j/jal and jr: `pc`=0x3000, `pc_op`=10, `instr_index`=26'h0000C10. Expect `pc`=0x0000_3040 and `pc_plus4`=0x3004 during EXEC. Then `pc_op`=11, `jr_target`=0x0000_3004. Expect `pc`=0x3004.
- Misaligned jr: `pc_op`=11, `jr_target`=0x0000_3006. Expect `pc` unchanged, `fault`=1, `halted`=1, `retired` unchanged. Further `exec_done`/`im_ack` pulses cause no change; `im_req` stays 0.
- Handshake stalls: hold `im_ack`=0 for 5 cycles. Expect `im_req` high and `pc` stable throughout. `exec_done` pulses during FETCH are ignored. Assert `rst_n`=0 during EXEC. Expect `pc`=0x3000, `retired`=0, state IDLE.
- Wrap: `RESET_PC`=32'hFFFF_FFFC, `pc_op`=00. Expect `pc`=0x0000_0000 and no fault. With `CNT_W`=2, four retirements bring `retired` back to 0.
